// File: rtl/arq_tx_scheduler.sv
// Stop-and-wait ARQ transmit sequencer: FIFO pop -> send with alternating seq -> await ack/nack/timeout.
// Latency: tx_valid rises 3 cycles after IDLE sees enable && !fifo_empty; outputs are registered or Moore.
// Backpressure: SEND holds tx_valid/tx_data until tx_ready; the response timer only runs in WAIT.
module arq_tx_scheduler #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 15,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_seq,
    input  logic                  tx_ready,
    input  logic                  ack,
    input  logic                  nack,
    input  logic                  rsp_seq,
    output logic                  retx,
    output logic                  frame_done,
    output logic                  frame_drop,
    output logic [CNT_WIDTH-1:0]  ok_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt,
    output logic                  busy,
    output logic [2:0]            state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t                cur, nxt;
    logic [DATA_WIDTH-1:0] frame;
    logic                  seq_q;
    logic [RW-1:0]         retry_cnt;
    logic [TW-1:0]         timer;
    logic                  retry_ev, done_ev, give_up;

    always_ff @(posedge clk) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    // A response always outranks the timeout; nack outranks a simultaneous ack.
    always_comb begin
        nxt      = cur;
        retry_ev = 1'b0;
        done_ev  = 1'b0;
        give_up  = 1'b0;
        unique case (cur)
            IDLE:  if (enable && !fifo_empty) nxt = FETCH;
            FETCH: nxt = LOAD;
            LOAD:  nxt = SEND;
            SEND:  if (tx_ready) nxt = WAIT;
            WAIT: begin
                if (nack || (ack && (rsp_seq != seq_q))) begin
                    retry_ev = 1'b1;
                end else if (ack) begin
                    done_ev = 1'b1;
                    nxt     = IDLE;
                end else if (timer == TMO_LAST) begin
                    retry_ev = 1'b1;
                end
                if (retry_ev) begin
                    give_up = (retry_cnt == RETRY_LAST);
                    nxt     = give_up ? IDLE : SEND;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame      <= '0;
            seq_q      <= 1'b0;
            retry_cnt  <= '0;
            timer      <= '0;
            retx       <= 1'b0;
            frame_done <= 1'b0;
            frame_drop <= 1'b0;
            ok_cnt     <= '0;
            drop_cnt   <= '0;
        end else begin
            frame_done <= done_ev;
            frame_drop <= give_up;
            if (cur == LOAD) begin
                frame     <= fifo_rd_data;
                retry_cnt <= '0;
                retx      <= 1'b0;
            end
            if (cur == SEND && tx_ready) timer <= '0;
            if (cur == WAIT)             timer <= timer + 1'b1;
            if (retry_ev && !give_up) begin
                retry_cnt <= retry_cnt + 1'b1;
                retx      <= 1'b1;
            end
            if (done_ev || give_up) seq_q <= ~seq_q;
            if (done_ev && (ok_cnt != '1))   ok_cnt   <= ok_cnt + 1'b1;
            if (give_up && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign fifo_rd_en = (cur == FETCH);
    assign tx_valid   = (cur == SEND);
    assign tx_data    = frame;
    assign tx_seq     = seq_q;
    assign busy       = (cur != IDLE);
    assign state      = cur;

endmodule

// File: tb/tb_arq_tx_scheduler.sv
// Bench for arq_tx_scheduler: bench-side FIFO and channel responder, frame-level reference model.
module tb_arq_tx_scheduler;

    localparam int DW = 4;
    localparam int MR = 3;
    localparam int TO = 15;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    localparam int K_ACK = 0, K_NACK = 1, K_BADSEQ = 2, K_BOTH = 3, K_NONE = 4;

    logic          clk = 1'b0;
    logic          rst, enable, fifo_empty, fifo_rd_en;
    logic [DW-1:0] fifo_rd_data, tx_data;
    logic          tx_valid, tx_seq, tx_ready, ack, nack, rsp_seq;
    logic          retx, frame_done, frame_drop, busy;
    logic [CW-1:0] ok_cnt, drop_cnt;
    logic [2:0]    state;

    arq_tx_scheduler #(.DATA_WIDTH(DW), .MAX_RETRY(MR), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_seq(tx_seq), .tx_ready(tx_ready),
        .ack(ack), .nack(nack), .rsp_seq(rsp_seq), .retx(retx),
        .frame_done(frame_done), .frame_drop(frame_drop),
        .ok_cnt(ok_cnt), .drop_cnt(drop_cnt), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame-level outcome bookkeeping only.
    bit mseq;
    int mok, mdrop;
    int plan_kind [MR+1];
    int plan_dly  [MR+1];
    bit plan_rand;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_valid"}, tx_valid, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_seq"}, tx_seq, 0);
        chk({tag, "_retx"}, retx, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_drop"}, frame_drop, 0);
        chk({tag, "_ok"}, ok_cnt, 0);
        chk({tag, "_dropcnt"}, drop_cnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, state, 0);
    endtask

    task automatic model_reset();
        mseq  = 1'b0;
        mok   = 0;
        mdrop = 0;
    endtask

    task automatic set_plan(input int k0, input int k1, input int k2, input int k3, input int dly);
        plan_kind[0] = k0; plan_kind[1] = k1; plan_kind[2] = k2; plan_kind[3] = k3;
        for (int i = 0; i <= MR; i++) plan_dly[i] = dly;
    endtask

    // One frame from FIFO push to final ack/drop; the FIFO holds only this frame.
    task automatic do_frame(input logic [DW-1:0] data, input int gap);
        bit lost, resolved;
        int stall, k, d, r;
        lost = 0;
        resolved = 0;
        enable = 1'b0;
        fifo_empty = 1'b0;
        repeat (gap) begin
            cyc();
            chk("hold_rd_en", fifo_rd_en, 0);
            chk("hold_state", state, 0);
        end
        enable = 1'b1;
        cyc();
        chk("fetch_state", state, 1);
        chk("fetch_rd_en", fifo_rd_en, 1);
        fifo_empty = 1'b1;
        fifo_rd_data = ~data;
        enable = 1'($urandom_range(0, 1));
        cyc();
        chk("load_state", state, 2);
        chk("load_rd_en", fifo_rd_en, 0);
        fifo_rd_data = data;
        cyc();
        fifo_rd_data = ~data;
        for (int s = 0; s <= MR; s++) begin
            stall = 0;
            forever begin
                chk("send_valid", tx_valid, 1);
                if (tx_valid !== 1'b1) begin
                    lost = 1;
                    break;
                end
                chk("tx_data", tx_data, data);
                chk("tx_seq", tx_seq, mseq);
                chk("retx", retx, s > 0);
                chk("send_busy", busy, 1);
                tx_ready = (stall >= 5) || ($urandom_range(0, 3) != 0);
                ack      = ($urandom_range(0, 3) == 0);
                nack     = ($urandom_range(0, 3) == 0);
                rsp_seq  = 1'($urandom);
                cyc();
                if (tx_ready) break;
                stall++;
            end
            tx_ready = 1'b0;
            ack = 1'b0;
            nack = 1'b0;
            if (lost) break;
            if (plan_rand) begin
                r = $urandom_range(0, 9);
                k = (r < 5) ? K_ACK : (r == 5) ? K_NACK : (r == 6) ? K_BADSEQ :
                    (r == 7) ? K_BOTH : K_NONE;
                d = $urandom_range(0, TO - 1);
            end else begin
                k = plan_kind[s];
                d = plan_dly[s];
            end
            for (int w = 0; w < TO; w++) begin
                chk("wait_state", state, 4);
                chk("wait_valid", tx_valid, 0);
                if (k != K_NONE && w == d) begin
                    ack     = (k != K_NACK);
                    nack    = (k == K_NACK) || (k == K_BOTH);
                    rsp_seq = (k == K_BADSEQ) ? ~mseq : mseq;
                    cyc();
                    ack = 1'b0;
                    nack = 1'b0;
                    break;
                end
                cyc();
            end
            if (k == K_ACK) begin
                mseq = ~mseq;
                mok  = (mok < CMAX) ? mok + 1 : CMAX;
                chk("done_pulse", frame_done, 1);
                chk("done_nodrop", frame_drop, 0);
                chk("done_state", state, 0);
                chk("ok_cnt", ok_cnt, mok);
                chk("drop_cnt", drop_cnt, mdrop);
                resolved = 1;
                break;
            end else if (s == MR) begin
                mseq  = ~mseq;
                mdrop = (mdrop < CMAX) ? mdrop + 1 : CMAX;
                chk("drop_pulse", frame_drop, 1);
                chk("drop_nodone", frame_done, 0);
                chk("drop_state", state, 0);
                chk("drop_cnt", drop_cnt, mdrop);
                chk("ok_cnt", ok_cnt, mok);
                resolved = 1;
            end else begin
                chk("retry_nodone", frame_done, 0);
                chk("retry_nodrop", frame_drop, 0);
            end
        end
        if (lost || !resolved) begin
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            model_reset();
        end else begin
            cyc();
            chk("pulse_clear_done", frame_done, 0);
            chk("pulse_clear_drop", frame_drop, 0);
            chk("idle_state", state, 0);
        end
    endtask

    initial begin
        logic [DW-1:0] t1 [4];
        t1 = '{4'h0, 4'hA, 4'h3, 4'h2};
        rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
        tx_ready = 1'b0; ack = 1'b0; nack = 1'b0; rsp_seq = 1'b0;
        plan_rand = 0;
        cyc();
        cyc();
        chk_zero("reset");
        rst = 1'b0;
        model_reset();

        enable = 1'b1;
        repeat (4) begin
            cyc();
            chk("empty_rd_en", fifo_rd_en, 0);
            chk("empty_state", state, 0);
        end

        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 0);
        for (int i = 0; i < 4; i++) do_frame(t1[i], 0);
        set_plan(K_NACK, K_ACK, K_ACK, K_ACK, 0);
        do_frame(4'hA, 1);
        set_plan(K_NACK, K_NACK, K_NACK, K_NACK, 0);
        do_frame(4'h3, 0);
        set_plan(K_NONE, K_NONE, K_NONE, K_NONE, 0);
        do_frame(4'h5, 0);
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, TO - 1);
        do_frame(4'h6, 0);
        set_plan(K_BADSEQ, K_BOTH, K_ACK, K_ACK, 2);
        do_frame(4'h9, 2);

        plan_rand = 1;
        repeat (300) do_frame(DW'($urandom), $urandom_range(0, 2));
        plan_rand = 0;

        fifo_empty = 1'b0;
        enable = 1'b1;
        fifo_rd_data = 4'hC;
        cyc();
        fifo_empty = 1'b1;
        cyc();
        tx_ready = 1'b1;
        cyc();
        cyc();
        tx_ready = 1'b0;
        chk("pre_rst_wait", state, 4);
        rst = 1'b1;
        cyc();
        chk_zero("midrst");
        rst = 1'b0;
        model_reset();
        cyc();
        chk("midrst_nodrop", frame_drop, 0);
        chk("midrst_idle", state, 0);
        set_plan(K_ACK, K_ACK, K_ACK, K_ACK, 1);
        do_frame(4'h7, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish within budget");
        $fatal(1);
    end

endmodule
